// File: rtl/wb_byte_master.sv
// Byte-stream to WISHBONE classic master bridge.
// Gathers a header, three address bytes and (for writes) four data bytes from
// the inbound stream. It then runs one single-beat bus cycle, with retry and
// timeout handling. Finally it returns a status byte, followed by read data
// when a read completes successfully.
module wb_byte_master #(
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_dat_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [19:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    input  logic [31:0] dat_i
);

    typedef enum logic [2:0] {
        S_HDR,
        S_ADR,
        S_WDAT,
        S_BUS,
        S_GAP,
        S_RESP_STAT,
        S_RESP_DAT
    } state_t;

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_RETRY   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    state_t      state, state_d;
    logic [1:0]  byte_cnt, byte_cnt_d;
    logic [3:0]  retry_cnt, retry_cnt_d;
    logic [15:0] tmo_cnt, tmo_cnt_d;
    logic [1:0]  status, status_d;
    logic [31:0] rdata, rdata_d;

    logic        cyc_d, stb_d, we_d, rx_ready_d, tx_valid_d;
    logic [19:0] adr_d;
    logic [31:0] dat_d;
    logic [3:0]  sel_d;
    logic [7:0]  tx_dat_d;

    logic        rx_fire, tx_fire;
    logic        start_bus, finish;

    assign rx_fire = rx_valid_i & rx_ready_o;
    assign tx_fire = tx_valid_o & tx_ready_i;

    // Next-state and next-output computation for every registered output
    always_comb begin
        state_d     = state;
        byte_cnt_d  = byte_cnt;
        retry_cnt_d = retry_cnt;
        tmo_cnt_d   = tmo_cnt;
        status_d    = status;
        rdata_d     = rdata;
        cyc_d       = cyc_o;
        stb_d       = stb_o;
        we_d        = we_o;
        adr_d       = adr_o;
        dat_d       = dat_o;
        sel_d       = sel_o;
        rx_ready_d  = rx_ready_o;
        tx_valid_d  = tx_valid_o;
        tx_dat_d    = tx_dat_o;
        start_bus   = 1'b0;
        finish      = 1'b0;

        case (state)
            S_HDR: begin
                if (rx_fire) begin
                    we_d        = rx_dat_i[7];
                    sel_d       = rx_dat_i[3:0];
                    byte_cnt_d  = 2'd0;
                    retry_cnt_d = 4'd0;
                    state_d     = S_ADR;
                end
            end
            S_ADR: begin
                if (rx_fire) begin
                    adr_d = {adr_o[11:0], rx_dat_i};
                    if (byte_cnt == 2'd2) begin
                        byte_cnt_d = 2'd0;
                        if (we_o) begin
                            state_d = S_WDAT;
                        end else begin
                            start_bus = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt + 2'd1;
                    end
                end
            end
            S_WDAT: begin
                if (rx_fire) begin
                    dat_d = {dat_o[23:0], rx_dat_i};
                    if (byte_cnt == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        start_bus  = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt + 2'd1;
                    end
                end
            end
            S_BUS: begin
                if (err_i) begin
                    status_d = ST_ERR;
                    finish   = 1'b1;
                end else if (ack_i) begin
                    if (!we_o) begin
                        rdata_d = dat_i;
                    end
                    status_d = ST_OK;
                    finish   = 1'b1;
                end else if (rty_i) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_cnt_d = retry_cnt + 4'd1;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        state_d     = S_GAP;
                    end else begin
                        status_d = ST_RETRY;
                        finish   = 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    status_d = ST_TIMEOUT;
                    finish   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt + 16'd1;
                end
            end
            S_GAP: begin
                start_bus = 1'b1;
            end
            S_RESP_STAT: begin
                if (tx_fire) begin
                    if (!we_o && status == ST_OK) begin
                        tx_dat_d   = rdata[31:24];
                        rdata_d    = {rdata[23:0], 8'h00};
                        byte_cnt_d = 2'd0;
                        state_d    = S_RESP_DAT;
                    end else begin
                        tx_valid_d = 1'b0;
                        rx_ready_d = 1'b1;
                        state_d    = S_HDR;
                    end
                end
            end
            S_RESP_DAT: begin
                if (tx_fire) begin
                    if (byte_cnt == 2'd3) begin
                        tx_valid_d = 1'b0;
                        rx_ready_d = 1'b1;
                        state_d    = S_HDR;
                    end else begin
                        tx_dat_d   = rdata[31:24];
                        rdata_d    = {rdata[23:0], 8'h00};
                        byte_cnt_d = byte_cnt + 2'd1;
                    end
                end
            end
            default: begin
                cyc_d      = 1'b0;
                stb_d      = 1'b0;
                tx_valid_d = 1'b0;
                rx_ready_d = 1'b1;
                state_d    = S_HDR;
            end
        endcase

        if (start_bus) begin
            cyc_d      = 1'b1;
            stb_d      = 1'b1;
            rx_ready_d = 1'b0;
            tmo_cnt_d  = 16'd0;
            state_d    = S_BUS;
        end

        if (finish) begin
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            tx_valid_d = 1'b1;
            tx_dat_d   = {6'd0, status_d};
            state_d    = S_RESP_STAT;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= S_HDR;
            byte_cnt   <= 2'd0;
            retry_cnt  <= 4'd0;
            tmo_cnt    <= 16'd0;
            status     <= 2'd0;
            rdata      <= 32'd0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= 20'd0;
            dat_o      <= 32'd0;
            sel_o      <= 4'd0;
            rx_ready_o <= 1'b1;
            tx_valid_o <= 1'b0;
            tx_dat_o   <= 8'd0;
        end else begin
            state      <= state_d;
            byte_cnt   <= byte_cnt_d;
            retry_cnt  <= retry_cnt_d;
            tmo_cnt    <= tmo_cnt_d;
            status     <= status_d;
            rdata      <= rdata_d;
            cyc_o      <= cyc_d;
            stb_o      <= stb_d;
            we_o       <= we_d;
            adr_o      <= adr_d;
            dat_o      <= dat_d;
            sel_o      <= sel_d;
            rx_ready_o <= rx_ready_d;
            tx_valid_o <= tx_valid_d;
            tx_dat_o   <= tx_dat_d;
        end
    end

endmodule

// File: tb/tb_wb_byte_master.sv
// Testbench for wb_byte_master: table of directed commands with a scripted
// slave, plus hand-written sequences for back-pressure and mid-operation reset.
module tb_wb_byte_master;

    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  rx_dat_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_dat_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        cyc_o, stb_o, we_o;
    logic [19:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
    logic [31:0] dat_i = 32'd0;

    wb_byte_master #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_dat_i(rx_dat_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_dat_o(tx_dat_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .dat_i(dat_i)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  hdr;
        logic [23:0] adr_bytes;
        logic [31:0] wdat;
        int          delay;
        int          n_rty;
        int          fin;
        logic [31:0] sdata;
        logic [19:0] exp_adr;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
        int          exp_attempts;
        int          exp_last_pulse;
        int          exp_ntx;
        logic [39:0] exp_tx;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    int          cfg_delay = 0;
    int          cfg_n_rty = 0;
    int          cfg_fin   = 2;
    logic [31:0] cfg_data  = 32'd0;
    int          slv_attempts = 0;
    int          s_k = 0;
    int          s_cur = 0;
    logic        s_prev = 1'b0;

    int          pulse_q[$];
    int          gap_q[$];
    int          run_len = 0;
    int          gap_len = 0;
    logic        m_prev = 1'b0;
    logic        snap_taken = 1'b0;
    logic [19:0] snap_adr;
    logic        snap_we;
    logic [3:0]  snap_sel;
    logic [31:0] snap_dat;
    logic        bus_unstable = 1'b0;
    logic        cyc_stb_diff = 1'b0;

    logic [7:0]  rx_q[$];
    logic        st_prev = 1'b0;
    logic [7:0]  st_dat = 8'd0;
    int          n_stall = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scripted slave: terminates attempt number s_cur on its cfg_delay-th stb cycle
    always begin
        @(posedge clk_i);
        #1;
        if (stb_o) begin
            if (!s_prev) begin
                s_k   = 0;
                s_cur = slv_attempts;
                slv_attempts++;
            end else begin
                s_k++;
            end
        end
        s_prev = stb_o;
        ack_i  = 1'b0;
        err_i  = 1'b0;
        rty_i  = 1'b0;
        dat_i  = 32'h0BAD_F00D;
        if (stb_o && s_k == cfg_delay) begin
            if (s_cur < cfg_n_rty) begin
                rty_i = 1'b1;
            end else if (cfg_fin == 0) begin
                ack_i = 1'b1;
                dat_i = cfg_data;
            end else if (cfg_fin == 1) begin
                err_i = 1'b1;
                ack_i = 1'b1;
                dat_i = cfg_data;
            end
        end
    end

    // Bus monitor: stb pulse lengths, gaps between attempts, signal stability
    always @(negedge clk_i) begin
        if (cyc_o !== stb_o) cyc_stb_diff = 1'b1;
        if (stb_o) begin
            if (!m_prev) begin
                if (pulse_q.size() > 0) gap_q.push_back(gap_len);
                run_len = 1;
            end else begin
                run_len++;
            end
            if (!snap_taken) begin
                snap_adr   = adr_o;
                snap_we    = we_o;
                snap_sel   = sel_o;
                snap_dat   = dat_o;
                snap_taken = 1'b1;
            end else if (adr_o !== snap_adr || we_o !== snap_we ||
                         sel_o !== snap_sel || dat_o !== snap_dat) begin
                bus_unstable = 1'b1;
            end
        end else begin
            if (m_prev) begin
                pulse_q.push_back(run_len);
                gap_len = 1;
            end else begin
                gap_len++;
            end
        end
        m_prev = stb_o;
    end

    // Response collector with hold check while the downstream stalls
    always @(negedge clk_i) begin
        if (st_prev) begin
            n_stall++;
            checkOutput("tx_hold_valid", tx_valid_o, 1'b1);
            checkOutput("tx_hold_dat", tx_dat_o, st_dat);
        end
        if (rst_i && tx_valid_o && tx_ready_i) rx_q.push_back(tx_dat_o);
        st_prev = rst_i && tx_valid_o && !tx_ready_i;
        st_dat  = tx_dat_o;
    end

    task automatic send_byte(input logic [7:0] b);
        logic ready_seen;
        logic accepted;
        accepted   = 1'b0;
        rx_dat_i   = b;
        rx_valid_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            ready_seen = rx_ready_o;
            @(posedge clk_i);
            #1;
            if (ready_seen) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("rx_accept", accepted, 1'b1);
    endtask

    task automatic send_cmd(input vec_t v);
        send_byte(v.hdr);
        send_byte(v.adr_bytes[23:16]);
        send_byte(v.adr_bytes[15:8]);
        send_byte(v.adr_bytes[7:0]);
        if (v.hdr[7]) begin
            send_byte(v.wdat[31:24]);
            send_byte(v.wdat[23:16]);
            send_byte(v.wdat[15:8]);
            send_byte(v.wdat[7:0]);
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic setup_vec(input vec_t v);
        cfg_delay    = v.delay;
        cfg_n_rty    = v.n_rty;
        cfg_fin      = v.fin;
        cfg_data     = v.sdata;
        slv_attempts = 0;
        pulse_q.delete();
        gap_q.delete();
        rx_q.delete();
        snap_taken   = 1'b0;
        bus_unstable = 1'b0;
        cyc_stb_diff = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic applyStimulus(input int idx);
        vec_t        v;
        logic        done;
        logic [39:0] act_tx;
        int          bad_gaps;
        int          last_pulse;
        v = vecs[idx];
        setup_vec(v);
        send_cmd(v);
        checkOutput($sformatf("v%0d_entry_cyc", idx), cyc_o, 1'b1);
        checkOutput($sformatf("v%0d_entry_rx_ready", idx), rx_ready_o, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i);
            #1;
            if (rx_ready_o) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput($sformatf("v%0d_done", idx), done, 1'b1);
        checkOutput($sformatf("v%0d_adr", idx), snap_adr, v.exp_adr);
        checkOutput($sformatf("v%0d_we", idx), snap_we, v.exp_we);
        checkOutput($sformatf("v%0d_sel", idx), snap_sel, v.exp_sel);
        if (v.exp_we) checkOutput($sformatf("v%0d_dat", idx), snap_dat, v.exp_dat);
        checkOutput($sformatf("v%0d_bus_stable", idx), bus_unstable, 1'b0);
        checkOutput($sformatf("v%0d_cyc_eq_stb", idx), cyc_stb_diff, 1'b0);
        checkOutput($sformatf("v%0d_attempts", idx), pulse_q.size(), v.exp_attempts);
        last_pulse = (pulse_q.size() > 0) ? pulse_q[pulse_q.size() - 1] : 0;
        checkOutput($sformatf("v%0d_last_pulse", idx), last_pulse, v.exp_last_pulse);
        bad_gaps = 0;
        foreach (gap_q[i]) if (gap_q[i] != 1) bad_gaps++;
        checkOutput($sformatf("v%0d_gaps", idx), bad_gaps, 0);
        checkOutput($sformatf("v%0d_ntx", idx), rx_q.size(), v.exp_ntx);
        act_tx = '0;
        foreach (rx_q[i]) act_tx = {act_tx[31:0], rx_q[i]};
        checkOutput($sformatf("v%0d_tx", idx), act_tx, v.exp_tx);
    endtask

    task automatic stall_during_data();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i);
            #1;
            if (rx_q.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("stall_start", seen, 1'b1);
        tx_ready_i = 1'b0;
        repeat (5) begin
            @(posedge clk_i);
            #1;
        end
        tx_ready_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, table of vectors, then hand-written corner cases
    initial begin
        vecs[0] = '{8'h0F, 24'h010004, 32'h0, 3, 0, 0, 32'hDEADBEEF,
                    20'h10004, 1'b0, 4'hF, 32'h0, 1, 4, 5, 40'h00DEADBEEF};
        vecs[1] = '{8'h83, 24'h080010, 32'h12345678, 0, 0, 0, 32'h0,
                    20'h80010, 1'b1, 4'h3, 32'h12345678, 1, 1, 1, 40'h00};
        vecs[2] = '{8'h05, 24'h0ABCDE, 32'h0, 1, 2, 0, 32'hCAFEF00D,
                    20'hABCDE, 1'b0, 4'h5, 32'h0, 3, 2, 5, 40'h00CAFEF00D};
        vecs[3] = '{8'hFC, 24'hF12345, 32'hA5A55A5A, 0, 100, 0, 32'h0,
                    20'h12345, 1'b1, 4'hC, 32'hA5A55A5A, 4, 1, 1, 40'h02};
        vecs[4] = '{8'h01, 24'h000000, 32'h0, 0, 0, 2, 32'h0,
                    20'h00000, 1'b0, 4'h1, 32'h0, 1, 16, 1, 40'h03};
        vecs[5] = '{8'h01, 24'h000100, 32'h0, 15, 0, 0, 32'h01234567,
                    20'h00100, 1'b0, 4'h1, 32'h0, 1, 16, 5, 40'h0001234567};
        vecs[6] = '{8'h0F, 24'h0FFFFF, 32'h0, 2, 0, 1, 32'h55AA55AA,
                    20'hFFFFF, 1'b0, 4'hF, 32'h0, 1, 3, 1, 40'h01};
        vecs[7] = '{8'h82, 24'h0C0C0C, 32'h87654321, 5, 1, 2, 32'h0,
                    20'hC0C0C, 1'b1, 4'h2, 32'h87654321, 2, 16, 1, 40'h03};

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_cyc", cyc_o, 1'b0);
        checkOutput("rst_stb", stb_o, 1'b0);
        checkOutput("rst_we", we_o, 1'b0);
        checkOutput("rst_tx_valid", tx_valid_o, 1'b0);
        checkOutput("rst_rx_ready", rx_ready_o, 1'b1);
        checkOutput("rst_adr", adr_o, 20'h0);
        checkOutput("rst_dat", dat_o, 32'h0);
        checkOutput("rst_sel", sel_o, 4'h0);
        checkOutput("rst_tx_dat", tx_dat_o, 8'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < NVEC; i++) applyStimulus(i);

        $display("[TB] read with downstream stall on data bytes");
        n_stall = 0;
        fork
            applyStimulus(0);
            stall_during_data();
        join
        checkOutput("stall_cycles", n_stall, 5);

        $display("[TB] reset in the middle of a bus cycle");
        setup_vec(vecs[4]);
        send_cmd(vecs[4]);
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        checkOutput("pre_reset_cyc", cyc_o, 1'b1);
        pulse_reset();
        checkOutput("bus_reset_cyc", cyc_o, 1'b0);
        checkOutput("bus_reset_tx_valid", tx_valid_o, 1'b0);
        checkOutput("bus_reset_rx_ready", rx_ready_o, 1'b1);
        repeat (20) begin
            @(posedge clk_i);
            #1;
        end
        checkOutput("bus_reset_no_resp", rx_q.size(), 0);
        applyStimulus(1);

        $display("[TB] reset in the middle of address collection");
        send_byte(8'h8F);
        send_byte(8'h0E);
        rx_valid_i = 1'b0;
        pulse_reset();
        checkOutput("adr_reset_cyc", cyc_o, 1'b0);
        checkOutput("adr_reset_tx_valid", tx_valid_o, 1'b0);
        checkOutput("adr_reset_rx_ready", rx_ready_o, 1'b1);
        applyStimulus(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
- Byte-stream to WISHBONE classic master bridge. It is the initiator side feeding one of the intercon's 20-bit master ports (turfc/hkmc style).
- It assembles read/write commands from an 8-bit valid/ready stream and runs one single-beat WISHBONE cycle per command.
- It handles ack/err/rty and a bus timeout, then returns a status byte plus read data on an outbound byte stream.

Parameters:
- TIMEOUT, 1024: cycles stb_o may stay high without ack/err/rty before the cycle is abandoned (1..65535).
- MAX_RETRY, 3: number of reissues after rty_i before reporting failure (0..15).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-low (0 = reset).
- rx_dat_i  in  8  command byte.
- rx_valid_i  in  1  command byte valid.
- rx_ready_o  out  1  bridge accepts the byte.
- tx_dat_o  out  8  response byte.
- tx_valid_o  out  1  response byte valid.
- tx_ready_i  in  1  downstream accepts the byte.
- cyc_o, stb_o, we_o  out  1 each  WISHBONE master controls.
- adr_o  out  20  byte address.
- dat_o  out  32  write data.
- sel_o  out  4  byte selects.
- ack_i, err_i, rty_i  in  1 each  WISHBONE terminations.
- dat_i  in  32  read data.

Behaviour:
- All outputs registered.
- Reset (rst_i=0 at a clk_i edge): state HDR; cyc_o/stb_o/we_o/tx_valid_o = 0; rx_ready_o = 1; adr_o/dat_o/tx_dat_o = 0; sel_o = 0; counters cleared.
- Transfer rule: a byte moves when valid & ready are both high at a rising edge.
- Command format, MSB first:
  - Header: bit7 = we, bits3:0 = sel, bits6:4 ignored.
  - 3 address bytes; upper nibble of the first is ignored, giving adr[19:0].
  - Writes only: 4 data bytes.
- States: HDR -> ADR (3 bytes) -> WDAT (writes only, 4 bytes) -> BUS -> RESP_STAT -> RESP_DAT (reads with ack only) -> HDR. GAP is entered from BUS on retry.
- rx_ready_o: 1 only in HDR/ADR/WDAT. It drops the cycle after the last command byte transfers.
- BUS entry: cyc_o = stb_o = 1 on the cycle after the last command byte; we_o/adr_o/dat_o/sel_o stable for the whole cycle.
- Termination sampled each cycle in BUS; priority err_i > ack_i > rty_i.
  - ack: latch dat_i if read; status 0x00.
  - err: status 0x01.
  - rty with retry count < MAX_RETRY: increment count, go to GAP (cyc_o/stb_o low exactly 1 cycle), then BUS again with identical address/data.
  - rty with count == MAX_RETRY: status 0x02.
  - Any termination deasserts cyc_o/stb_o on the next edge. At least one cycle with cyc_o = 0 always separates commands.
- Timeout counter:
  - Resets to 0 on every BUS entry (including each retry); increments each BUS cycle without a termination.
  - If it reaches TIMEOUT-1 with no termination, cyc_o/stb_o drop next edge and status = 0x03.
  - A termination on the same cycle wins over the timeout.
- Response:
  - RESP_STAT drives tx_valid_o = 1 with the status byte.
  - Reads with status 0x00 then send 4 bytes from latched dat_i, MSB first.
  - Writes, and any failed status, send the status byte only.
  - tx_dat_o held stable while tx_valid_o=1 & tx_ready_i=0.
  - The next header is accepted only after the last response byte transfers; no overlap of command and response.
- Inputs ignored outside their states: ack/err/rty outside BUS; rx_valid_i while rx_ready_o = 0.
- Reset mid-operation (any state): partial command discarded, bus cycle abandoned immediately (cyc_o = 0 next edge), pending response dropped.

Test Plan:
1. Read: send 0x0F,0x01,0x00,0x04; slave acks 3 cycles after stb with dat_i=0xDEADBEEF.
   -> adr_o=0x10004, we_o=0, sel_o=0xF; cyc_o high one cycle after the last byte, low one cycle after ack.
   -> tx bytes 0x00,0xDE,0xAD,0xBE,0xEF.
2. Write: send 0x83,0x08,0x00,0x10,0x12,0x34,0x56,0x78; immediate ack.
   -> adr_o=0x80010, dat_o=0x12345678, sel_o=0x3, we_o=1; tx single byte 0x00.
3. Retry, MAX_RETRY=3:
   -> rty twice then ack: three stb_o pulses, each separated by exactly one cyc_o=0 cycle; status 0x00.
   -> rty always: 4 attempts, then status 0x02 and no data bytes.
4. Timeout, TIMEOUT=16, slave silent on a read:
   -> stb_o high exactly 16 cycles, then low; tx single byte 0x03.
   -> ack arriving on cycle 16 instead yields 0x00 plus data.
5. err_i and ack_i asserted together -> status 0x01 only. With tx_ready_i held low 5 cycles during read data, tx_dat_o stays stable and no byte is lost or duplicated.
6. rst_i=0 for one cycle mid-BUS and mid-ADR:
   -> next cycle cyc_o=0, tx_valid_o=0, rx_ready_o=1.
   -> a fresh command then executes correctly with no stale address bytes.
